dmem_lsu: RTL and testbench

Load/store unit for the Memory stage of the 5-stage RISC-V pipeline. It consumes the Execute→Memory register outputs: ALUResultM as the address, WriteDataM as store data, and funct3M as the access size. It drives a word-wide data-memory bus with a ready handshake and returns sign- or zero-extended ReadDataM to the M→W pipeline register. While an access is outstanding it raises StallM to the hazard unit, which freezes the F/D/E/M stages.

---
 rtl/dmem_lsu.sv | 217 +++++++++++++++++++++
 tb/tb_dmem_lsu.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_lsu.sv
// dmem_lsu -- Memory-stage load/store unit for the 5-stage RISC-V pipeline.
//
// Accepts a load or store from the E/M register, issues one word-wide request
// on the data-memory bus, waits for mem_ready (or a timeout), and returns the
// sign/zero-extended load data. The pipeline is held while the access is open.
//
// Ports:
//   clk, reset          pipeline clock (rising edge), async active-low reset
//   MemReadM/MemWriteM  load / store request (store wins when both are set)
//   funct3M             access size and signedness
//   ALUResultM          byte address
//   WriteDataM          right-aligned store data
//   ReadDataM           registered, extended load result
//   StallM              combinational pipeline hold
//   MisalignM           combinational misaligned / reserved-funct3 flag
//   BusErrM             registered one-cycle timeout pulse
//   mem_req/we/addr/wdata/be   registered bus request fields
//   mem_ready/mem_rdata        bus completion and read word
module dmem_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        MisalignM,
    output logic        BusErrM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_e;

    localparam logic [9:0] CNT_LAST = 10'(TIMEOUT_CYCLES - 1);

    state_e      state_q, state_d;
    logic [9:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  alo_q, alo_d;

    // Request decode
    logic        valid;
    logic        illegal;
    logic        accept;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;

    assign valid = MemReadM | MemWriteM;

    // Loads reserve 011/110/111; stores only define 000..010.
    always_comb begin
        if (MemWriteM) begin
            illegal = (funct3M > 3'b010);
        end else begin
            illegal = (funct3M[1:0] == 2'b11) || (funct3M[2] && funct3M[1]);
        end
    end

    always_comb begin
        MisalignM = 1'b0;
        if (state_q == S_IDLE && valid) begin
            MisalignM = illegal
                     || (funct3M[1:0] == 2'b01 && ALUResultM[0])
                     || (funct3M[1:0] == 2'b10 && ALUResultM[1:0] != 2'b00);
        end
    end

    assign accept = (state_q == S_IDLE) && valid && !MisalignM;

    always_comb begin
        be_c    = 4'b1111;
        wdata_c = WriteDataM;
        case (funct3M[1:0])
            2'b00: begin
                be_c    = 4'b0001 << ALUResultM[1:0];
                wdata_c = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                be_c    = ALUResultM[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{WriteDataM[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = WriteDataM;
            end
        endcase
    end

    // Load formatting uses the offset/size captured at request time, since
    // the inputs are not guaranteed to describe this access by completion.
    logic [31:0] shifted;
    logic [31:0] load_fmt;

    assign shifted = mem_rdata >> {alo_q, 3'b000};

    always_comb begin
        case (f3_q[1:0])
            2'b00:   load_fmt = {{24{~f3_q[2] & shifted[7]}}, shifted[7:0]};
            2'b01:   load_fmt = {{16{~f3_q[2] & shifted[15]}}, shifted[15:0]};
            default: load_fmt = mem_rdata;
        endcase
    end

    // Next-state / outputs
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        f3_d    = f3_q;
        alo_d   = alo_q;
        StallM  = 1'b0;

        case (state_q)
            S_IDLE: begin
                StallM = accept;
                if (accept) begin
                    req_d   = 1'b1;
                    we_d    = MemWriteM;
                    addr_d  = {ALUResultM[31:2], 2'b00};
                    wdata_d = wdata_c;
                    be_d    = be_c;
                    f3_d    = funct3M;
                    alo_d   = ALUResultM[1:0];
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                StallM = 1'b1;
                if (mem_ready) begin
                    if (!we_q) rdata_d = load_fmt;
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    if (!we_q) rdata_d = '0;
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 10'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            f3_q    <= '0;
            alo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            f3_q    <= f3_d;
            alo_q   <= alo_d;
        end
    end

    assign ReadDataM = rdata_q;
    assign BusErrM   = err_q;
    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_be    = be_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// tb_dmem_lsu -- randomized self-checking bench for dmem_lsu.
// Expected bus fields and load results come from arithmetic on the
// access description; ReadDataM is tracked as a single expected register.
module tb_dmem_lsu;

    localparam int unsigned TMO = 4;

    logic        clk;
    logic        reset;
    logic        MemReadM;
    logic        MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        MisalignM;
    logic        BusErrM;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int unsigned npass;
    int unsigned ntotal;
    logic [31:0] rd_exp;

    dmem_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .funct3M    (funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .MisalignM  (MisalignM),
        .BusErrM    (BusErrM),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", npass, ntotal);
        $fatal(1);
    end

    // One complete access (or an idle cycle when neither MemReadM nor
    // MemWriteM is set). Entered and left 1 time unit after a rising edge,
    // with the DUT in IDLE. dly = BUSY cycle index at which mem_ready is
    // driven; dly >= TMO means the bus never answers.
    task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rdat, input int unsigned dly,
                             input string tag);
        logic        valid, st, ill, mis, tmo;
        int unsigned sz, nbusy, nstall;
        logic [3:0]  be;
        logic [31:0] wexp, lexp, v, wa;

        valid = rd | wr;
        st    = wr;
        sz    = int'(f3) % 4;
        if (st) ill = (f3 > 3'd2);
        else    ill = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        mis = valid && (ill || (sz == 1 && a[0]) || (sz == 2 && a[1:0] != 2'b00));

        if (sz == 0)      be = 4'(1 << a[1:0]);
        else if (sz == 1) be = a[1] ? 4'hC : 4'h3;
        else              be = 4'hF;

        if (sz == 0)      wexp = {24'd0, wd[7:0]} * 32'h0101_0101;
        else if (sz == 1) wexp = {16'd0, wd[15:0]} * 32'h0001_0001;
        else              wexp = wd;

        v = rdat >> (8 * int'(a[1:0]));
        if (sz == 0) begin
            lexp = v & 32'hFF;
            if (!f3[2] && v[7]) lexp = lexp | 32'hFFFF_FF00;
        end else if (sz == 1) begin
            lexp = v & 32'hFFFF;
            if (!f3[2] && v[15]) lexp = lexp | 32'hFFFF_0000;
        end else begin
            lexp = rdat;
        end

        wa    = a & 32'hFFFF_FFFC;
        tmo   = (dly >= TMO);
        nbusy = tmo ? TMO : dly + 1;

        MemReadM   = rd;
        MemWriteM  = wr;
        funct3M    = f3;
        ALUResultM = a;
        WriteDataM = wd;
        mem_ready  = 1'($urandom % 2);
        mem_rdata  = $urandom;

        @(negedge clk);
        ntotal++;
        if ({BusErrM, mem_req, MisalignM, StallM} !== {1'b0, 1'b0, mis, valid && !mis})
            $display("FAIL %s idle {err,req,mis,stall}: got %b want %b", tag,
                     {BusErrM, mem_req, MisalignM, StallM}, {1'b0, 1'b0, mis, valid && !mis});
        else npass++;
        ntotal++;
        if (ReadDataM !== rd_exp)
            $display("FAIL %s idle ReadDataM: got %h want %h", tag, ReadDataM, rd_exp);
        else npass++;
        nstall = StallM ? 1 : 0;

        if (!valid || mis) begin
            @(posedge clk);
            if (mis) begin
                @(negedge clk);
                ntotal++;
                if ({mem_req, ReadDataM} !== {1'b0, rd_exp})
                    $display("FAIL %s misalign {req,rdata}: got %h want %h", tag,
                             {mem_req, ReadDataM}, {1'b0, rd_exp});
                else npass++;
                @(posedge clk);
            end
            #1;
            return;
        end

        @(posedge clk);
        for (int unsigned k = 0; k < nbusy; k++) begin
            #1;
            mem_ready = (k == dly);
            mem_rdata = (k == dly) ? rdat : $urandom;
            @(negedge clk);
            ntotal++;
            if ({mem_req, mem_we, mem_be, mem_addr} !== {1'b1, st, be, wa})
                $display("FAIL %s busy%0d {req,we,be,addr}: got %h want %h", tag, k,
                         {mem_req, mem_we, mem_be, mem_addr}, {1'b1, st, be, wa});
            else npass++;
            if (st) begin
                ntotal++;
                if (mem_wdata !== wexp)
                    $display("FAIL %s busy%0d wdata: got %h want %h", tag, k, mem_wdata, wexp);
                else npass++;
            end
            if (StallM) nstall++;
            @(posedge clk);
        end
        #1;
        mem_ready = 1'($urandom % 2);
        mem_rdata = $urandom;
        if (!st) rd_exp = tmo ? 32'd0 : lexp;

        @(negedge clk);
        ntotal++;
        if ({StallM, mem_req, BusErrM} !== {1'b0, 1'b0, tmo})
            $display("FAIL %s done {stall,req,err}: got %b want %b", tag,
                     {StallM, mem_req, BusErrM}, {1'b0, 1'b0, tmo});
        else npass++;
        ntotal++;
        if (ReadDataM !== rd_exp)
            $display("FAIL %s done ReadDataM: got %h want %h", tag, ReadDataM, rd_exp);
        else npass++;
        ntotal++;
        if (nstall !== nbusy + 1)
            $display("FAIL %s stall cycles: got %0d want %0d", tag, nstall, nbusy + 1);
        else npass++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset      = 1'b0;
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        funct3M    = 3'd0;
        ALUResultM = 32'd0;
        WriteDataM = 32'd0;
        mem_ready  = 1'b0;
        mem_rdata  = 32'd0;
        rd_exp     = 32'd0;
        #12;
        @(negedge clk);
        ntotal++;
        if ({ReadDataM, BusErrM, mem_req, mem_we, mem_addr, mem_wdata, mem_be, StallM, MisalignM} !== '0)
            $display("FAIL reset outputs: got rdata=%h err=%b req=%b we=%b addr=%h wdata=%h be=%h stall=%b mis=%b want all zero",
                     ReadDataM, BusErrM, mem_req, mem_we, mem_addr, mem_wdata, mem_be, StallM, MisalignM);
        else npass++;
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_lw_basic();
        do_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, "lw_0x100");
    endtask

    task automatic test_lb_lbu();
        do_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 0, "lb_0x103");
        do_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_1234, 1, "lbu_0x103");
        do_access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h9ABC_0000, 2, "lh_0x102");
        do_access(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h9ABC_0000, 0, "lhu_0x102");
    endtask

    task automatic test_sh_wait();
        do_access(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000_ABCD, 32'h0, 2, "sh_0x202");
        do_access(1'b1, 1'b1, 3'b000, 32'h301, 32'h1234_56A5, 32'h0, 1, "rdwr_sb_0x301");
    endtask

    task automatic test_misalign();
        do_access(1'b1, 1'b0, 3'b001, 32'h101, 32'h0, 32'h0, 0, "mis_lh_0x101");
        do_access(1'b1, 1'b0, 3'b010, 32'h106, 32'h0, 32'h0, 0, "mis_lw_0x106");
        do_access(1'b0, 1'b1, 3'b011, 32'h100, 32'h0, 32'h0, 0, "ill_st_011");
        do_access(1'b1, 1'b0, 3'b110, 32'h100, 32'h0, 32'h0, 0, "ill_ld_110");
    endtask

    task automatic test_timeout();
        do_access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'h0, TMO, "timeout_lw");
        do_access(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 0, "after_timeout");
    endtask

    task automatic test_async_reset();
        MemReadM   = 1'b1;
        MemWriteM  = 1'b0;
        funct3M    = 3'b010;
        ALUResultM = 32'h80;
        mem_ready  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        rd_exp = 32'd0;
        ntotal++;
        if ({mem_req, mem_be, ReadDataM} !== {1'b0, 4'h0, 32'd0})
            $display("FAIL async_reset {req,be,rdata}: got %h want 0", {mem_req, mem_be, ReadDataM});
        else npass++;
        MemReadM = 1'b0;
        @(negedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #1;
        do_access(1'b0, 1'b1, 3'b010, 32'h10, 32'hCAFE_F00D, 32'h0, 0, "sw_0x10_after_reset");
    endtask

    task automatic test_back_to_back();
        do_access(1'b1, 1'b0, 3'b010, 32'h500, 32'h0, 32'h1357_9BDF, 0, "b2b_lw");
        do_access(1'b0, 1'b1, 3'b000, 32'h502, 32'h0000_00EE, 32'h0, 0, "b2b_sb");
        do_access(1'b1, 1'b0, 3'b000, 32'h501, 32'h0, 32'h0000_7F00, 0, "b2b_lb");
    endtask

    task automatic test_random();
        logic [2:0] legal_f3 [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
        for (int i = 0; i < 80; i++) begin
            logic        rd, wr;
            logic [2:0]  f3;
            int unsigned r;
            r  = $urandom % 8;
            rd = (r < 4) || (r == 6);
            wr = (r >= 3) && (r != 6) && (r != 7);
            if ($urandom % 4 == 0) f3 = 3'($urandom);
            else                   f3 = legal_f3[$urandom % 5];
            do_access(rd, wr, f3, $urandom, $urandom, $urandom, $urandom % 6, "random");
        end
    endtask

    initial begin
        npass  = 0;
        ntotal = 0;
        test_reset();
        test_lw_basic();
        test_lb_lbu();
        test_sh_wait();
        test_misalign();
        test_timeout();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
